dot_product_engine: RTL and testbench

Sequential responder on the MultAdder side of the fully-connected layer interface. It accepts two 128-lane vectors of 8-bit sign-magnitude operands: activations from RAM and weights from ROM. It returns one 15-bit sign-magnitude dot product plus an overflow flag. The layer controllers (full_connect1/2) issue operands with a start pulse and wait for valid before they add the bias and apply ReLU.

---
 rtl/dot_product_engine_pkg.sv | 13 +
 rtl/dot_product_engine_if.sv | 15 +
 rtl/dot_product_engine_sm8_mult.sv | 14 +
 rtl/dot_product_engine.sv | 89 ++++++++
 tb/tb_dot_product_engine.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/dot_product_engine_pkg.sv
// fc_pkg: shared sizes, number formats and FSM states for the fully-connected datapath
// Exports: N, LANES, ACC_W, SM8_W, SM15_W, SM15_MAG_MAX, GROUPS, CNT_W, state_e
package fc_pkg;
    localparam int N            = 128;
    localparam int LANES        = 8;
    localparam int ACC_W        = 22;
    localparam int SM8_W        = 8;
    localparam int SM15_W       = 15;
    localparam int SM15_MAG_MAX = 16383;
    localparam int GROUPS       = N / LANES;
    localparam int CNT_W        = $clog2(GROUPS);
    typedef enum logic [1:0] {IDLE, ACCUM, FINAL, DONE} state_e;
endpackage

// File: rtl/dot_product_engine_if.sv
// dot_product_engine_if: operand/result handshake between a layer controller and the MultAdder
// master (controller): drives start, opr1, opr2; samples busy, valid, result, overflow
// slave  (engine)    : the reverse
interface dot_product_engine_if;
    import fc_pkg::*;
    logic                  start;
    logic [N*SM8_W-1:0]    opr1;
    logic [N*SM8_W-1:0]    opr2;
    logic                  busy;
    logic                  valid;
    logic [SM15_W-1:0]     result;
    logic                  overflow;
    modport master(output start, opr1, opr2, input busy, valid, result, overflow);
    modport slave(input start, opr1, opr2, output busy, valid, result, overflow);
endinterface

// File: rtl/dot_product_engine_sm8_mult.sv
// sm8_mult: combinational 8x8 sign-magnitude multiply to a 16-bit two's-complement product
// i_a, i_b : sign-magnitude operands (bit7 sign, bits6:0 magnitude)
// o_p      : signed product, magnitude in units of 2^-14
module sm8_mult
    import fc_pkg::*;
(
    input  logic [SM8_W-1:0]          i_a,
    input  logic [SM8_W-1:0]          i_b,
    output logic signed [2*SM8_W-1:0] o_p
);
    logic [2*SM8_W-3:0] w_mag;
    assign w_mag = i_a[SM8_W-2:0] * i_b[SM8_W-2:0];
    assign o_p   = (i_a[SM8_W-1] ^ i_b[SM8_W-1]) ? -$signed({2'b00, w_mag}) : $signed({2'b00, w_mag});
endmodule

// File: rtl/dot_product_engine.sv
// dot_product_engine: sequential 128-lane sign-magnitude dot product, LANES multiplies per cycle
// clk    : rising-edge clock
// iRst_n : asynchronous active-low reset, aborts any request in flight
// bus    : slave side of dot_product_engine_if (start/opr1/opr2 in, busy/valid/result/overflow out)
module dot_product_engine
    import fc_pkg::*;
(
    input  logic                 clk,
    input  logic                 iRst_n,
    dot_product_engine_if.slave  bus
);
    state_e                   r_state;
    logic [N*SM8_W-1:0]       r_opr1;
    logic [N*SM8_W-1:0]       r_opr2;
    logic signed [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]         r_cnt;
    logic [SM15_W-1:0]        r_result;
    logic                     r_overflow;
    logic [LANES*SM8_W-1:0]   w_grp_a;
    logic [LANES*SM8_W-1:0]   w_grp_b;
    logic signed [2*SM8_W-1:0] w_prod [LANES];
    logic signed [ACC_W-1:0]  w_grp_sum;
    logic                     w_neg;
    logic                     w_sat;
    logic [ACC_W-1:0]         w_abs;

    assign w_grp_a = r_opr1[r_cnt*LANES*SM8_W +: LANES*SM8_W];
    assign w_grp_b = r_opr2[r_cnt*LANES*SM8_W +: LANES*SM8_W];

    for (genvar g = 0; g < LANES; g++) begin : g_mult
        sm8_mult u_mult (
            .i_a (w_grp_a[g*SM8_W +: SM8_W]),
            .i_b (w_grp_b[g*SM8_W +: SM8_W]),
            .o_p (w_prod[g])
        );
    end

    always_comb begin
        w_grp_sum = '0;
        for (int i = 0; i < LANES; i++)
            w_grp_sum = w_grp_sum + ACC_W'(w_prod[i]);
    end

    // ACC_W keeps every partial sum exact, so only the final value is saturated
    assign w_neg = r_acc[ACC_W-1];
    assign w_abs = w_neg ? -r_acc : r_acc;
    assign w_sat = w_abs > ACC_W'(SM15_MAG_MAX);

    // operands are latched once per request so the controller may change them afterwards
    always_ff @(posedge clk)
        if (r_state == IDLE && bus.start) begin
            r_opr1 <= bus.opr1;
            r_opr2 <= bus.opr2;
        end

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= ACCUM;
                end
                ACCUM: begin
                    r_acc   <= r_acc + w_grp_sum;
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= (r_cnt == CNT_W'(GROUPS-1)) ? FINAL : ACCUM;
                end
                FINAL: begin
                    r_result   <= {w_neg, w_sat ? (SM15_W-1)'(SM15_MAG_MAX) : w_abs[SM15_W-2:0]};
                    r_overflow <= w_sat;
                    r_state    <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = r_state != IDLE;
    assign bus.valid    = r_state == DONE;
    assign bus.result   = r_result;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_dot_product_engine.sv
// tb_dot_product_engine: directed and random checks of dot_product_engine against an arithmetic model
module tb_dot_product_engine;
    import fc_pkg::*;

    localparam int VW = N * SM8_W;
    localparam int LAT = GROUPS + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    dot_product_engine_if bus();

    dot_product_engine dut (
        .clk    (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // exact dot product with plain integers, then the 15-bit sign-magnitude rules
    function automatic logic [15:0] ref_dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
        int s = 0;
        int m;
        int mag;
        logic ovf;
        for (int i = 0; i < N; i++) begin
            m = int'(a[8*i +: 7]) * int'(b[8*i +: 7]);
            s += (a[8*i+7] ^ b[8*i+7]) ? -m : m;
        end
        mag = (s < 0) ? -s : s;
        ovf = mag > 16383;
        return {ovf, s < 0, ovf ? 14'h3FFF : mag[13:0]};
    endfunction

    function automatic logic [VW-1:0] rvec(input int mode);
        logic [VW-1:0] v;
        logic [7:0] b;
        for (int i = 0; i < N; i++) begin
            b = 8'($urandom);
            if (mode == 1) b[6:4] = 3'b000;
            if (mode == 2 && $urandom_range(0, 7) != 0) b = 8'h00;
            v[8*i +: 8] = b;
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] fill(input logic [7:0] lo, input logic [7:0] hi, input int split);
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[8*i +: 8] = (i < split) ? lo : hi;
        return v;
    endfunction

    // timeline model: accept when idle, result appears LAT edges later, busy ends one edge after
    logic        m_act = 1'b0;
    int          m_t = 0;
    logic [15:0] m_pend = '0;
    logic [14:0] m_res = '0;
    logic        m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 1'b0;
            m_t   <= 0;
            m_res <= '0;
            m_ovf <= 1'b0;
        end else if (!m_act) begin
            if (bus.start) begin
                m_act  <= 1'b1;
                m_t    <= 0;
                m_pend <= ref_dot(bus.opr1, bus.opr2);
            end
        end else begin
            m_t <= m_t + 1;
            if (m_t == LAT - 1) begin
                m_res <= m_pend[14:0];
                m_ovf <= m_pend[15];
            end
            if (m_t == LAT) m_act <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("busy", bus.busy, m_act);
        chk("valid", bus.valid, m_act && m_t == LAT);
        chk("result", bus.result, m_res);
        chk("overflow", bus.overflow, m_ovf);
    end

    task automatic issue(input logic [VW-1:0] a, input logic [VW-1:0] b);
        @(negedge clk);
        bus.opr1 = a;
        bus.opr2 = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.opr1 = rvec(0);
        bus.opr2 = rvec(0);
    endtask

    task automatic run(input string nm, input logic [VW-1:0] a, input logic [VW-1:0] b,
                       input logic [14:0] er, input logic eo, input int poke);
        int k = 1;
        int nv = 0;
        issue(a, b);
        while (!bus.valid && k < 40) begin
            bus.start = (k == poke);
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        chk({nm, " latency"}, k - 1, LAT);
        chk({nm, " result"}, bus.result, er);
        chk({nm, " overflow"}, bus.overflow, eo);
        repeat (25) begin
            @(negedge clk);
            nv += int'(bus.valid);
        end
        chk({nm, " extra valid"}, nv, 0);
    endtask

    logic [VW-1:0] a1, b1, z;

    initial begin
        int nv;
        z  = '0;
        a1 = '0;
        b1 = '0;
        a1[7:0] = 8'h7F;
        b1[7:0] = 8'h7F;
        bus.start = 1'b0;
        bus.opr1 = '0;
        bus.opr2 = '0;

        chk("pin 7F*7F", ref_dot(a1, b1), 16'h3F01);
        chk("pin all 40", ref_dot(fill(8'h40, 8'h40, N), fill(8'h40, 8'h40, N)), 16'hBFFF);
        chk("pin all C0", ref_dot(fill(8'hC0, 8'hC0, N), fill(8'h40, 8'h40, N)), 16'hFFFF);
        chk("pin half cancel", ref_dot(fill(8'h7F, 8'hFF, 64), fill(8'h7F, 8'h7F, N)), 16'h0000);

        repeat (2) @(negedge clk);
        chk("reset busy", bus.busy, 0);
        chk("reset valid", bus.valid, 0);
        chk("reset result", bus.result, 0);
        chk("reset overflow", bus.overflow, 0);
        #2 rst_n = 1'b1;

        run("lane0 max", a1, b1, 15'h3F01, 1'b0, 0);
        begin
            logic [VW-1:0] a, b;
            a = z; b = z;
            a[47:40] = 8'h85;
            b[47:40] = 8'h03;
            run("lane5 neg", a, b, 15'h400F, 1'b0, 0);
            a = a1; b = b1;
            a[15:8] = 8'hFF;
            b[15:8] = 8'h7F;
            run("neg zero", a, b, 15'h0000, 1'b0, 0);
        end
        run("sat pos", fill(8'h40, 8'h40, N), fill(8'h40, 8'h40, N), 15'h3FFF, 1'b1, 0);
        run("sat neg", fill(8'hC0, 8'hC0, N), fill(8'h40, 8'h40, N), 15'h7FFF, 1'b1, 0);
        run("no mid sat", fill(8'h7F, 8'hFF, 64), fill(8'h7F, 8'h7F, N), 15'h0000, 1'b0, 0);
        run("sat again", fill(8'hC0, 8'hC0, N), fill(8'h40, 8'h40, N), 15'h7FFF, 1'b1, 0);
        run("restart ignored", a1, b1, 15'h3F01, 1'b0, 5);

        run("pre abort", fill(8'hC0, 8'hC0, N), fill(8'h40, 8'h40, N), 15'h7FFF, 1'b1, 0);
        issue(a1, b1);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", bus.busy, 0);
        chk("abort valid", bus.valid, 0);
        chk("abort result", bus.result, 0);
        chk("abort overflow", bus.overflow, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        nv = 0;
        repeat (25) begin
            @(negedge clk);
            nv += int'(bus.valid);
        end
        chk("abort no valid", nv, 0);
        run("after abort", a1, b1, 15'h3F01, 1'b0, 0);

        repeat (1500) begin
            int m;
            @(negedge clk);
            m = $urandom_range(0, 2);
            bus.start = ($urandom_range(0, 4) == 0);
            bus.opr1 = rvec(m);
            bus.opr2 = rvec(m);
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (25) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
